fifo16: RTL and testbench
=========================

# fifo16

Synchronous 16-bit, 8-entry FIFO that decouples a word producer from a word consumer on the same clock. The write side captures 16-bit words just as a plain 16-bit register captures `d`. The read side returns them in order through a registered `rd_data` output. It sits between datapath stages that produce and consume 16-bit words at uneven rates, for example a result buffer feeding a writeback or output stage.

## Interface
- `WIDTH`, 16, data word width in bits
- `DEPTH`, 8, number of entries; must be a power of two
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  reset, synchronous and active-high
- `wr_en`  input  1  push request
- `wr_data`  input  WIDTH  word to push
- `full`  output  1  high when count == DEPTH
- `rd_en`  input  1  pop request
- `rd_data`  output  WIDTH  last popped word, registered
- `rd_valid`  output  1  one-cycle pulse: `rd_data` was updated by a pop at the previous edge
- `empty`  output  1  high when count == 0
- `count`  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
- `overflow`  output  1  sticky: a push was dropped
- `underflow`  output  1  sticky: a pop was ignored

## Operation
- Storage is an array of DEPTH words.
  - Write pointer `wp` and read pointer `rp` are each $clog2(DEPTH) bits wide.
  - Both pointers wrap modulo DEPTH (7 -> 0).
  - `count` is held as a separate register; it is not derived from the pointers.
- A push is accepted when `wr_en` is high and either `!full` or a pop is also accepted in the same cycle.
  - Accepted push: `mem[wp] <= wr_data`, then `wp` increments.
- A pop is accepted when `rd_en` is high and `!empty`.
  - Accepted pop: `rd_data <= mem[rp]`, `rp` increments, `rd_valid <= 1`.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
- Push with pop on an empty FIFO:
  - The pop is ignored and `underflow` is set.
  - The push is accepted; `count` becomes 1.
  - There is no bypass from `wr_data` to `rd_data`.
- Push with pop on a full FIFO:
  - Both are accepted; `count` stays DEPTH.
  - The pop reads the old `mem[rp]` before the write lands.
- Push while full with no pop: the word is dropped, `overflow` is set, no state changes.
- Pop while empty: `rd_data` holds its value, `rd_valid` is 0, `underflow` is set.
- `overflow` and `underflow` clear only on `rst`.
- `rd_data` keeps its value whenever no pop is accepted.

## Timing
- Reset values, applied on the first rising edge with `rst` high:
  - `wp` = 0, `rp` = 0, `count` = 0
  - `empty` = 1, `full` = 0
  - `rd_data` = 16'h0000, `rd_valid` = 0
  - `overflow` = 0, `underflow` = 0
  - Memory contents are not reset.
- `rst` has priority over `wr_en` and `rd_en` in the same cycle. Reset mid-operation discards all stored words.
- Push latency: a word pushed at edge N can be popped with `rd_en` sampled at edge N+1, and appears on `rd_data` after edge N+1.
- `full`, `empty` and `count` reflect state after the most recent edge. They are combinational from the `count` register and have no dependence on the current inputs.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_WIDTH` = 16 and `FIFO_DEPTH` = 8
  - a `fifo_word_t` typedef for `logic [FIFO_WIDTH-1:0]`
- The `rd_data` output register is an instance of the existing 16-bit `dff` cell (sync reset `rst`).
  - It is driven through a hold mux: `d = pop ? mem[rp] : rd_data`.
- Storage, pointers, count and flags stay in `fifo16`. No other sub-module.

## Test plan
- **Reset:** hold `rst` 2 cycles -> `empty`=1, `full`=0, `count`=0, `rd_data`=16'h0000, `rd_valid`=0, both sticky flags 0.
- **Fill and drain:**
  - Push 16'h1111..16'h8888 on 8 consecutive edges -> `full`=1, `count`=8.
  - Pop 8 times -> `rd_data` sequence 16'h1111..16'h8888, each with `rd_valid`=1; `empty`=1 after the last pop.
- **Overflow:** with the FIFO full, push 16'hDEAD -> `count` stays 8, `overflow`=1. Draining yields no 16'hDEAD.
- **Underflow:** from empty, `rd_en`=1 for 1 cycle -> `rd_valid`=0, `rd_data` unchanged, `underflow`=1.
- **Simultaneous push/pop:**
  - Empty FIFO, push 16'hA5A5 with pop -> `count`=1, `underflow`=1; the next pop returns 16'hA5A5.
  - Full FIFO, push 16'hBEEF with pop -> `count`=8, pop returns the oldest word, 16'hBEEF later exits in order.
- **Wrap and reset:**
  - Run 20 interleaved push/pop cycles so the pointers wrap twice; data order is preserved.
  - Assert `rst` with `count`=5 -> next cycle `count`=0, `empty`=1, flags cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 16-bit word FIFO and its output register cell.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/dff.sv
// 16-bit D register with synchronous active-high reset to zero.
module dff
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  fifo_word_t d,
  output fifo_word_t q
);

  // word register, cleared by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 16'h0000;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo16.sv
// 8-entry x 16-bit synchronous FIFO with registered read data and sticky
// overflow/underflow flags.
module fifo16
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_r;
  logic [AW-1:0]    rp_r;
  logic [CW-1:0]    count_r;
  logic             rd_valid_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  fifo_word_t       rd_d_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  // a full FIFO still takes a push when a pop frees the slot on the same edge
  assign pop_s   = rd_en && !empty_s;
  assign push_s  = wr_en && (!full_s || pop_s);

  // storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem[wp_r] <= wr_data;
    end
  end

  // pointers, occupancy, read strobe and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r        <= {AW{1'b0}};
      rp_r        <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) wp_r <= wp_r + AW'(1);
      if (pop_s)  rp_r <= rp_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      rd_valid_r <= pop_s;
      if (wr_en && !push_s) overflow_r  <= 1'b1;
      if (rd_en && !pop_s)  underflow_r <= 1'b1;
    end
  end

  // hold mux in front of the read data register
  always_comb begin
    rd_d_s = rd_data;
    if (pop_s) begin
      rd_d_s = mem[rp_r];
    end else begin
      rd_d_s = rd_data;
    end
  end

  dff u_rd_data (
    .clk (clk),
    .rst (rst),
    .d   (rd_d_s),
    .q   (rd_data)
  );

  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign rd_valid  = rd_valid_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_fifo16.sv
// Scenario-based self-checking bench for fifo16 with a queue scoreboard.
module tb_fifo16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        rd_en = 1'b0;
  logic        full, empty, rd_valid, overflow, underflow;
  logic [15:0] rd_data;
  logic [3:0]  count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb [$];
  int          m_cnt = 0;
  logic [15:0] m_last = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  fifo16 dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_cnt = 0;
    m_last = 16'h0000;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // drive one cycle and advance the reference model; popped tells whether a pop was accepted
  task automatic step(input logic we, input logic [15:0] wd, input logic re, output logic popped);
    logic pop_ok, push_ok;
    pop_ok  = re && (m_cnt != 0);
    push_ok = we && ((m_cnt < 8) || pop_ok);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(posedge clk);
    if (pop_ok) m_last = sb.pop_front();
    if (push_ok) sb.push_back(wd);
    if (push_ok && !pop_ok) m_cnt = m_cnt + 1;
    if (pop_ok && !push_ok) m_cnt = m_cnt - 1;
    if (we && !push_ok) m_ovf = 1'b1;
    if (re && !pop_ok) m_unf = 1'b1;
    popped = pop_ok;
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    logic p;
    logic [15:0] want;
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      want = 16'h1111 * 16'(i + 1);
      step(1'b1, want, 1'b0, p);
      checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    for (int i = 0; i < 8; i++) begin
      want = 16'h1111 * 16'(i + 1);
      step(1'b0, 16'h0000, 1'b1, p);
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b want 1", rd_valid); end
      checks++; if (rd_data !== want || rd_data !== m_last) begin
        errors++; $display("FAIL drain_data: got %h want %h", rd_data, want);
      end
    end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL drain_empty: got empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_overflow();
    logic p;
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, p);
    step(1'b1, 16'hDEAD, 1'b0, p);
    checks++; if (count !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL ovf_count: got count=%0d full=%b want 8 1", count, full);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0000, 1'b1, p);
      checks++; if (rd_data === 16'hDEAD || rd_data !== m_last || rd_data !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL ovf_drain: got %h want %h", rd_data, 16'h0100 + 16'(i));
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_underflow();
    logic p;
    do_reset(1);
    step(1'b1, 16'h1234, 1'b0, p);
    step(1'b0, 16'h0000, 1'b1, p);
    step(1'b0, 16'h0000, 1'b1, p);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL unf_valid: got %b want 0", rd_valid); end
    checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL unf_hold: got %h want 1234", rd_data); end
    checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL unf_flags: got unf=%b ovf=%b want 1 0", underflow, overflow);
    end
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL unf_count: got %0d want 0", count);
    end
  endtask

  task automatic test_simultaneous();
    logic p;
    do_reset(1);
    step(1'b1, 16'hA5A5, 1'b1, p);
    checks++; if (count !== 4'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL sim_empty: got count=%0d unf=%b valid=%b want 1 1 0", count, underflow, rd_valid);
    end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL sim_no_bypass: got %h want 0000", rd_data); end
    step(1'b0, 16'h0000, 1'b1, p);
    checks++; if (rd_data !== 16'hA5A5 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL sim_empty_pop: got %h valid=%b want a5a5 1", rd_data, rd_valid);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, p);
    step(1'b1, 16'hBEEF, 1'b1, p);
    checks++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL sim_full_count: got count=%0d ovf=%b want 8 0", count, overflow);
    end
    checks++; if (rd_data !== 16'h2000 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL sim_full_pop: got %h want 2000", rd_data);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0000, 1'b1, p);
      checks++; if (rd_data !== m_last || rd_valid !== p) begin
        errors++; $display("FAIL sim_drain: got %h want %h", rd_data, m_last);
      end
    end
    checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL sim_beef_last: got %h want beef", rd_data); end
  endtask

  task automatic test_wrap_reset();
    logic p;
    do_reset(1);
    step(1'b0, 16'h0000, 1'b1, p);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, p);
    for (int i = 3; i < 23; i++) begin
      step(1'b1, 16'h3000 + 16'(i), 1'b1, p);
      checks++; if (rd_valid !== 1'b1 || rd_data !== m_last || rd_data !== 16'h3000 + 16'(i - 3)) begin
        errors++; $display("FAIL wrap_data: got %h want %h", rd_data, 16'h3000 + 16'(i - 3));
      end
    end
    step(1'b1, 16'h4000, 1'b0, p);
    step(1'b1, 16'h4001, 1'b0, p);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count: got %0d want 5", count); end
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 16'h5555;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    m_cnt = 0;
    m_last = 16'h0000;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL rst_mid_count: got count=%0d empty=%b want 0 1", count, empty);
    end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_flags: got unf=%b ovf=%b valid=%b data=%h want 0 0 0 0000",
                         underflow, overflow, rd_valid, rd_data);
    end
    step(1'b1, 16'h7777, 1'b0, p);
    step(1'b0, 16'h0000, 1'b1, p);
    checks++; if (rd_data !== 16'h7777 || empty !== 1'b1) begin
      errors++; $display("FAIL rst_mid_discard: got %h empty=%b want 7777 1", rd_data, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
